// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension pipeline: mode codes and
// skid-buffer occupancy encoding.
package imm_ext_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ZERO  = 2'b00;
  localparam mode_t MODE_SIGN  = 2'b01;
  localparam mode_t MODE_UPPER = 2'b10;
  localparam mode_t MODE_RSVD  = 2'b11;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Request/response handshake bundle for imm_ext_pipe. The producer/consumer
// side uses the master modport, the pipeline uses the slave modport.
interface imm_ext_pipe_if #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign and upper (shifted) modes;
// the reserved mode extends as zero and flags err.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W     = 10,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned UP_SHIFT = 16
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  if (IN_W < 1 || IN_W > OUT_W || IN_W + UP_SHIFT > OUT_W) begin : g_bad_params
    $error("imm_ext_core: illegal IN_W/OUT_W/UP_SHIFT combination");
  end

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = OUT_W'(imm);
  // Size cast of a signed operand sign-extends, and also covers IN_W == OUT_W.
  assign sext = OUT_W'($signed(imm));

  always_comb begin
    data = zext;
    err  = 1'b0;
    unique case (mode)
      MODE_ZERO:  data = zext;
      MODE_SIGN:  data = sext;
      MODE_UPPER: data = zext << UP_SHIFT;
      MODE_RSVD: begin
        data = zext;
        err  = 1'b1;
      end
      default: data = zext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer: 1-cycle
// latency, full throughput, registered in_ready and a tag carried per request.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W     = 10,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned UP_SHIFT = 16,
  parameter int unsigned TAG_W    = 4
) (
  input logic          clk,
  input logic          rst_n,
  imm_ext_pipe_if.slave bus
);

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .UP_SHIFT(UP_SHIFT)
  ) u_core (
    .imm (bus.in_imm),
    .mode(bus.in_mode),
    .data(ext_data),
    .err (ext_err)
  );

  logic [1:0]       state_q, state_d;
  logic             ready_q;
  logic [OUT_W-1:0] main_data_q, skid_data_q;
  logic [TAG_W-1:0] main_tag_q, skid_tag_q;
  logic             main_err_q, skid_err_q;

  logic accept, pop;
  logic load_main, load_skid, shift_skid;

  assign accept = bus.in_valid & ready_q;
  assign pop    = (state_q != ST_EMPTY) & bus.out_ready;

  always_comb begin
    state_d    = state_q;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (accept && pop) begin
          load_main = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d    = ST_ONE;
          shift_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b0;
      main_data_q <= '0;
      main_tag_q  <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered from next state so out_ready never reaches in_ready combinationally.
      ready_q <= (state_d != ST_FULL);
      if (load_main) begin
        main_data_q <= ext_data;
        main_tag_q  <= bus.in_tag;
        main_err_q  <= ext_err;
      end else if (shift_skid) begin
        main_data_q <= skid_data_q;
        main_tag_q  <= skid_tag_q;
        main_err_q  <= skid_err_q;
      end
      if (load_skid) begin
        skid_data_q <= ext_data;
        skid_tag_q  <= bus.in_tag;
        skid_err_q  <= ext_err;
      end
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_data_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.out_err   = main_err_q;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Pipelined, parametrised immediate-extension stage for the datapath feeding the set-associative cache address/ALU path. It generalises the fixed 10-to-32 zero extender: configurable input/output widths, four extension modes and a valid/ready handshake. A 2-entry skid buffer gives 1-cycle latency and full throughput under backpressure. A tag travels with each immediate so consumers can match results to requests.

Parameters:
IN_W, 10, immediate input width (1..OUT_W)
OUT_W, 32, extended output width
UP_SHIFT, 16, left shift applied in UPPER mode; IN_W+UP_SHIFT <= OUT_W, otherwise elaboration error
TAG_W, 4, width of the sideband tag passed through unchanged

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  stage can accept; registered
in_imm  in  IN_W  immediate to extend
in_mode  in  2  extension mode
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_data  out  OUT_W  extended value
out_tag  out  TAG_W  tag of the result
out_err  out  1  result used the reserved mode

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Modes:
  - 00 ZERO: {zeros, imm}.
  - 01 SIGN: imm[IN_W-1] replicated to OUT_W.
  - 10 UPPER: imm << UP_SHIFT, low bits zero, upper unused bits zero.
  - 11 reserved: computes as ZERO and sets err=1. err=0 for all other modes.
- Transfer rules:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - Extension is computed combinationally at the input and registered on acceptance.
- Storage: main register (drives outputs) plus skid register. State tracks occupancy.
  - EMPTY: accept -> ONE (main loads).
  - ONE:
    - accept & !pop -> FULL (skid loads).
    - accept & pop -> ONE (main loads new entry).
    - pop only -> EMPTY.
    - neither -> hold.
  - FULL: no accept possible. pop -> ONE (main <= skid).
- in_ready = (state != FULL), driven from a register. No combinational path from out_ready to in_ready.
- Latency and throughput:
  - Request accepted at edge N is on the outputs with out_valid=1 after edge N.
  - Throughput is 1 per cycle while out_ready=1.
  - Strict FIFO order is preserved.
- Stability: while out_valid & !out_ready, out_data, out_tag and out_err hold.
- in_valid while in_ready=0 has no effect; the producer must hold the request.
- Reset values:
  - State EMPTY; out_valid=0, out_data=0, out_tag=0, out_err=0.
  - in_ready=0 while rst_n low; becomes 1 at the first rising clk edge after deassertion.
  - Reset mid-operation discards both entries immediately; no partial output.
- Width edge cases:
  - IN_W==OUT_W: ZERO and SIGN pass imm unchanged.
  - IN_W==1, SIGN: output is all ones or all zeros.

Decomposition:
- Package imm_ext_pkg:
  - Mode localparams MODE_ZERO=2'b00, MODE_SIGN=2'b01, MODE_UPPER=2'b10, MODE_RSVD=2'b11.
  - Occupancy state encoding EMPTY/ONE/FULL.
- Sub-module imm_ext_core: purely combinational, parametrised by IN_W/OUT_W/UP_SHIFT; inputs imm and mode, outputs data and err.
- imm_ext_pipe instantiates imm_ext_core and implements the skid buffer and handshake.

Test Plan:
- Defaults, out_ready=1, ZERO, in_imm=10'h3FF, tag=1 -> next cycle out_valid=1, out_data=32'h000003FF, out_tag=1, out_err=0.
- SIGN: 10'h200 -> 32'hFFFFFE00; 10'h1FF -> 32'h000001FF. Back-to-back in consecutive cycles -> outputs in consecutive cycles, same order.
- UPPER 10'h3FF -> 32'h03FF0000. Reserved mode 11 with 10'h155 -> 32'h00000155, out_err=1.
- Backpressure:
  - Stimulus: out_ready=0; present tags 1,2,3 continuously.
  - Tags 1,2 are accepted and in_ready drops to 0; tag 3 is held and outputs stay stable.
  - Raise out_ready -> outputs tags 1,2,3 in order, one per cycle; in_ready returns to 1 the cycle after the first pop.
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle with FULL occupancy.
  - out_valid=0 and outputs=0 immediately, without a clk edge; in_ready=0.
  - After release: in_ready=1 after the first edge, and no stale result ever appears.
- Alternate parameters IN_W=16, OUT_W=32, UP_SHIFT=16, SIGN 16'h8000 -> 32'hFFFF8000; UPPER 16'h1234 -> 32'h12340000.
